i2c_reg_ctrl: RTL
=================

I2C_REG_CTRL -- requirements
Module: i2c_reg_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, meaning number of 8-bit registers (power of 2, 2..256).
REQ-002 SHALL have parameter RESET_VAL, default 8'h00, meaning the reset value of every register.
REQ-003 SHALL derive AW = max(1, clog2(NUM_REGS)) as the register-address width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port frame_start_i  input  1  single-cycle pulse on an I2C START or repeated START addressed to this slave.
REQ-007 SHALL have port frame_stop_i  input  1  single-cycle pulse on an I2C STOP.
REQ-008 SHALL have port byte_valid_i  input  1  single-cycle pulse when a received byte is valid.
REQ-009 SHALL have port byte_data_i  input  8  the received byte, qualified by byte_valid_i.
REQ-010 SHALL have port rd_addr_i  input  AW  the host read address.
REQ-011 SHALL have port rd_data_o  output  8  the registered read data for rd_addr_i.
REQ-012 SHALL have port wr_strobe_o  output  1  one-cycle pulse per register write.
REQ-013 SHALL have port wr_addr_o  output  AW  the address of the write flagged by wr_strobe_o.
REQ-014 SHALL have port wr_data_o  output  8  the data of the write flagged by wr_strobe_o.
REQ-015 SHALL have port ptr_o  output  AW  the current register pointer.
REQ-016 SHALL have port busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-017 SHALL have port err_o  output  1  sticky flag set when a pointer byte is out of range.
REQ-018 SHALL have port err_clr_i  input  1  clears err_o.
REQ-019 SHALL have port byte_cnt_o  output  8  data bytes written in the current frame, saturating at 255.

Function
REQ-020 SHALL implement the FSM states IDLE, WAIT_PTR, WRITE and DISCARD.
REQ-021 SHALL treat frame_start_i as highest priority in any state: go to WAIT_PTR, clear byte_cnt_o, and drop any byte_valid_i in the same cycle.
REQ-022 SHALL, in IDLE, ignore byte_valid_i and frame_stop_i.
REQ-023 SHALL, in WAIT_PTR on byte_valid_i with byte_data_i < NUM_REGS, load ptr and go to WRITE; otherwise set err_o, leave ptr unchanged and go to DISCARD.
REQ-024 SHALL, in WRITE on byte_valid_i, write reg[ptr] and assert wr_strobe_o/wr_addr_o/wr_data_o one cycle later, increment byte_cnt_o and advance ptr.
REQ-025 SHALL advance ptr modulo NUM_REGS, wrapping from NUM_REGS-1 to 0.
REQ-026 SHALL, in DISCARD, ignore bytes and write nothing until frame_start_i or frame_stop_i.
REQ-027 SHALL, on frame_stop_i in WAIT_PTR/WRITE/DISCARD, go to IDLE; a byte_valid_i in the same cycle is processed first.
REQ-028 SHALL register rd_data_o with one-cycle latency; a write and read to the same address in one cycle returns the old value.
REQ-029 SHALL retain ptr_o across frames; it is changed only by a pointer byte, an increment or reset.
REQ-030 SHALL clear err_o on err_clr_i, except that a simultaneous set wins.

Reset
REQ-031 SHALL, while rst is high, set state=IDLE, all registers=RESET_VAL, ptr_o=0, rd_data_o=RESET_VAL, wr_strobe_o=0, wr_addr_o=0, wr_data_o=0, err_o=0, byte_cnt_o=0 and busy_o=0.
REQ-032 SHALL, on rst mid-frame, abort the frame with no pending write strobe issued.

Configuration
REQ-033 SHALL, with macro I2C_REG_CTRL_AUTOINC_EN defined, advance ptr after each data write (REQ-024/025).
REQ-034 SHALL, without I2C_REG_CTRL_AUTOINC_EN, hold ptr constant so successive data bytes overwrite the same register.

Structure
REQ-035 SHALL take the FSM state typedef (i2c_reg_state_t) and the constant I2C_BYTE_W=8 from the shared package i2c_pkg.
REQ-036 SHALL place the register array and registered read port in sub-module i2c_regfile (NUM_REGS, RESET_VAL; one write port, one read port).

Verification
REQ-037 SHALL verify: start, 0x03, 0xA5, stop -> reg[3]=0xA5, one wr_strobe with addr 3, byte_cnt=1, busy low after stop.
REQ-038 SHALL verify (AUTOINC_EN): start, 0x0F, 0x11, 0x22 -> reg[15]=0x11, reg[0]=0x22, ptr_o=1.
REQ-039 SHALL verify: start, 0x20 with NUM_REGS=16 -> err_o=1, state DISCARD, subsequent 0x55 causes no write; err_clr_i clears err_o.
REQ-040 SHALL verify: frame_start_i and byte_valid_i in the same cycle -> byte dropped, state WAIT_PTR, byte_cnt=0.
REQ-041 SHALL verify: rst asserted one cycle after a data byte -> no wr_strobe, all registers=RESET_VAL.
REQ-042 SHALL verify (without AUTOINC_EN): start, 0x02, 0x01, 0x02, 0x03 -> reg[2]=0x03, three strobes all with addr 2.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register controller: FSM state encoding
// and the byte width used on every data path.
package i2c_pkg;

   localparam int I2C_BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_PTR = 2'd1,
      WRITE    = 2'd2,
      DISCARD  = 2'd3
   } i2c_reg_state_t;

endpackage : i2c_pkg

// File: rtl/i2c_regfile.sv
// Register array for the I2C register controller: one synchronous write
// port and one registered read port. A read of the address being written
// in the same cycle returns the value held before the write.
module i2c_regfile
   import i2c_pkg::*;
#(
   parameter int                    NUM_REGS  = 16,
   parameter logic [I2C_BYTE_W-1:0] RESET_VAL = 8'h00,
   localparam int                   AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [I2C_BYTE_W-1:0] wdata_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [I2C_BYTE_W-1:0] rdata_o
);

   logic [I2C_BYTE_W-1:0] mem_q [NUM_REGS];
   logic [I2C_BYTE_W-1:0] rdata_q;

   // Storage update and registered read; the read samples the pre-write contents.
   // NOTE: every register has a defined reset value, so the array is reset
   // element by element here; this keeps it out of plain RAM macros, which is
   // acceptable for a small control register bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, which is what gives the read-old-value behaviour.
            mem_q[i] <= RESET_VAL;
         end
         rdata_q <= RESET_VAL;
      end else begin
         if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
         end
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule : i2c_regfile

// File: rtl/i2c_reg_ctrl.sv
// I2C slave register controller. Receives framed bytes from an I2C byte
// engine: the first byte after START is a register pointer, following bytes
// are written to the register bank. Bad pointers set a sticky error and the
// rest of the frame is discarded.
// Build option: define I2C_REG_CTRL_AUTOINC_EN to advance the pointer after
// every data write; by default the pointer holds, so successive data bytes
// overwrite the same register.
module i2c_reg_ctrl
   import i2c_pkg::*;
#(
   parameter int                    NUM_REGS  = 16,
   parameter logic [I2C_BYTE_W-1:0] RESET_VAL = 8'h00,
   localparam int                   AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_start_i,
   input  logic                  frame_stop_i,
   input  logic                  byte_valid_i,
   input  logic [I2C_BYTE_W-1:0] byte_data_i,
   input  logic [AW-1:0]         rd_addr_i,
   output logic [I2C_BYTE_W-1:0] rd_data_o,
   output logic                  wr_strobe_o,
   output logic [AW-1:0]         wr_addr_o,
   output logic [I2C_BYTE_W-1:0] wr_data_o,
   output logic [AW-1:0]         ptr_o,
   output logic                  busy_o,
   output logic                  err_o,
   input  logic                  err_clr_i,
   output logic [I2C_BYTE_W-1:0] byte_cnt_o
);

   localparam logic [I2C_BYTE_W-1:0] CNT_MAX = '1;

   i2c_reg_state_t state_q, state_d;

   logic [AW-1:0]         ptr_q, ptr_d;
   logic                  err_q, err_d;
   logic [I2C_BYTE_W-1:0] cnt_q, cnt_d;
   logic                  wr_strobe_q;
   logic [AW-1:0]         wr_addr_q;
   logic [I2C_BYTE_W-1:0] wr_data_q;

   logic ptr_in_range;
   logic ptr_load;
   logic wr_en;
   logic err_set;

   assign ptr_in_range = (int'(byte_data_i) < NUM_REGS);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: START overrides everything, STOP ends any active frame.
   always_comb begin
      // NOTE: defaulting every output of a combinational block before any
      // branch is what keeps synthesis from inferring latches.
      state_d = state_q;
      if (frame_start_i) begin
         state_d = WAIT_PTR;
      end else begin
         case (state_q)
            WAIT_PTR: if (byte_valid_i) state_d = ptr_in_range ? WRITE : DISCARD;
            IDLE, WRITE, DISCARD: state_d = state_q;
            default:  state_d = IDLE;
         endcase
         if (frame_stop_i && (state_q != IDLE)) begin
            state_d = IDLE;
         end
      end
   end

   // FSM outputs: decode what the current byte does. A byte in the START
   // cycle is dropped; a byte in the STOP cycle is still processed.
   always_comb begin
      ptr_load = 1'b0;
      wr_en    = 1'b0;
      err_set  = 1'b0;
      if (byte_valid_i && !frame_start_i) begin
         case (state_q)
            WAIT_PTR: begin
               ptr_load = ptr_in_range;
               err_set  = !ptr_in_range;
            end
            WRITE:   wr_en = 1'b1;
            default: ;
         endcase
      end
   end

   // Datapath next state: pointer, sticky error and per-frame byte counter.
   always_comb begin
      ptr_d = ptr_q;
      if (ptr_load) begin
         ptr_d = byte_data_i[AW-1:0];
      end else if (wr_en) begin
`ifdef I2C_REG_CTRL_AUTOINC_EN
         ptr_d = ptr_q + AW'(1);
`else
         ptr_d = ptr_q;
`endif
      end

      // A new error in the same cycle as a clear request must not be lost.
      err_d = err_q;
      if (err_set) begin
         err_d = 1'b1;
      end else if (err_clr_i) begin
         err_d = 1'b0;
      end

      cnt_d = cnt_q;
      if (frame_start_i) begin
         cnt_d = '0;
      end else if (wr_en && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Datapath registers and the registered write notification.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         wr_strobe_q <= wr_en;
         if (wr_en) begin
            wr_addr_q <= ptr_q;
            wr_data_q <= byte_data_i;
         end
      end
   end

   i2c_regfile #(
      .NUM_REGS  (NUM_REGS),
      .RESET_VAL (RESET_VAL)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_en),
      .waddr_i (ptr_q),
      .wdata_i (byte_data_i),
      .raddr_i (rd_addr_i),
      .rdata_o (rd_data_o)
   );

   // The write being flagged is wiped by a reset in the same cycle, so the
   // strobe is suppressed rather than announcing a register that no longer
   // holds the data.
   assign wr_strobe_o = wr_strobe_q & ~rst;
   assign wr_addr_o   = wr_addr_q;
   assign wr_data_o   = wr_data_q;
   assign ptr_o       = ptr_q;
   assign busy_o      = (state_q != IDLE);
   assign err_o       = err_q;
   assign byte_cnt_o  = cnt_q;

endmodule : i2c_reg_ctrl
